// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin, burst-limited arbiter that merges several
// valid/ready requesters onto one registered valid/ready output stream.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy,
  output logic [15:0]                     beat_count
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_grant_idx;
  logic [IDX_W-1:0]        r_last_grant;
  logic [7:0]              r_burst_cnt;
  logic [15:0]             r_beat_cnt;
  logic                    r_vld_p1;
  logic [DATA_WIDTH-1:0]   r_data_p1;
  logic                    r_last_p1;

  logic [IDX_W-1:0]        w_start;
  logic [2*NUM_REQ-1:0]    w_req_dbl;
  logic [IDX_W-1:0]        w_off;
  logic [IDX_W:0]          w_sum;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_any_req;
  logic                    w_g_valid;
  logic                    w_g_last;
  logic [DATA_WIDTH-1:0]   w_g_data;
  logic                    w_granted;
  logic                    w_can_load;
  logic                    w_accept;
  logic [7:0]              w_burst_nxt;
  logic                    w_release;

  // Round-robin pick: rotate requests so the search starts after the last grantee
  always_comb begin
    w_start = (r_last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_last_grant + 1'b1;
    w_req_dbl = {req_valid, req_valid} >> w_start;
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_dbl[i]) w_off = IDX_W'(i);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_arb_idx = IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ));
    else                              w_arb_idx = w_sum[IDX_W-1:0];
    w_any_req = |req_valid;
  end

  // Select the granted requester's valid/last/data; all others are ignored
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_idx == IDX_W'(i)) begin
        w_g_valid = req_valid[i];
        w_g_last  = req_last[i];
        w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake decode: output register can take a beat when empty or draining
  always_comb begin
    w_granted   = (r_state == S_GRANT);
    w_can_load  = !r_vld_p1 || out_ready;
    w_accept    = w_granted && w_g_valid && w_can_load;
    w_burst_nxt = r_burst_cnt + 8'd1;
    w_release   = w_granted &&
                  (!w_g_valid || (w_accept && (w_g_last || (w_burst_nxt == BURST_LIM))));
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_granted && w_can_load && (r_grant_idx == IDX_W'(i));
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until a release condition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant bookkeeping: grantee, round-robin pointer and per-grant beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_grant_idx <= w_arb_idx;
        r_burst_cnt <= '0;
      end else if (w_accept) begin
        r_burst_cnt <= w_burst_nxt;
      end
      if (w_release) r_last_grant <= r_grant_idx;
    end
  end

  // ---- stage p1: registered output beat ----
  // Output register: load on accept, clear when drained without a new beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_last_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_g_data;
      r_last_p1 <= w_g_last;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // Running count of accepted beats, wraps at 2^16
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_beat_cnt <= '0;
    else if (w_accept) r_beat_cnt <= r_beat_cnt + 16'd1;
  end

  assign out_valid  = r_vld_p1;
  assign out_data   = r_data_p1;
  assign out_last   = r_last_p1;
  assign grant_idx  = r_grant_idx;
  assign busy       = w_granted;
  assign beat_count = r_beat_cnt;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: single requester, contention,
// backpressure, valid drop, reset mid-burst and beat counter wrap.
module tb_stream_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [15:0] beat_count;

  // second instance with a long burst limit, used for the counter wrap
  logic [1:0]  w_req_valid;
  logic [1:0]  w_req_ready;
  logic [15:0] w_req_data;
  logic [1:0]  w_req_last;
  logic        w_out_valid;
  logic [7:0]  w_out_data;
  logic        w_out_last;
  logic [0:0]  w_grant_idx;
  logic        w_busy;
  logic [15:0] w_beat_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .grant_idx(grant_idx), .busy(busy), .beat_count(beat_count)
  );

  stream_rr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(255)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_data(w_req_data), .req_last(w_req_last),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_last(w_out_last),
    .grant_idx(w_grant_idx), .busy(w_busy), .beat_count(w_beat_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] d);
    req_data[idx*8 +: 8] = d;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    out_ready   = 1'b1;
    w_req_valid = '0;
    w_req_data  = 16'h3C3C;
    w_req_last  = '0;

    // reset state
    #12;
    check_val("rst_ready", 32'(req_ready), 32'h0);
    check_val("rst_valid", 32'(out_valid), 32'h0);
    check_val("rst_data",  32'(out_data),  32'h0);
    check_val("rst_gnt",   32'(grant_idx), 32'h0);
    check_val("rst_busy",  32'(busy),      32'h0);
    check_val("rst_bc",    32'(beat_count), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // single requester 1: 0x11 then 0x22 (last)
    req_valid = 4'b0010;
    set_data(1, 8'h11);
    #1;
    check_val("t1_idle_ready", 32'(req_ready), 32'h0);
    step();
    check_val("t1_gnt",   32'(grant_idx), 32'd1);
    check_val("t1_busy",  32'(busy),      32'd1);
    check_val("t1_ready", 32'(req_ready), 32'b0010);
    step();
    check_val("t1_v0",  32'(out_valid),  32'd1);
    check_val("t1_d0",  32'(out_data),   32'h11);
    check_val("t1_bc1", 32'(beat_count), 32'd1);
    set_data(1, 8'h22);
    req_last[1] = 1'b1;
    step();
    check_val("t1_d1",    32'(out_data),   32'h22);
    check_val("t1_last",  32'(out_last),   32'd1);
    check_val("t1_rel",   32'(busy),       32'd0);
    check_val("t1_bc2",   32'(beat_count), 32'd2);
    req_valid = '0;
    req_last  = '0;
    step();
    check_val("t1_drain", 32'(out_valid), 32'd0);

    // fresh reset so requester 0 has top priority
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    step();

    // full contention, no last: order 0,1,2,3,0, four beats each
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 8'hC0 + 8'(i));
    for (int r = 0; r < 5; r++) begin
      step();
      check_val("t2_gnt",  32'(grant_idx), 32'(r % 4));
      check_val("t2_busy", 32'(busy),      32'd1);
      for (int b = 0; b < 4; b++) begin
        check_val("t2_ready", 32'(req_ready), 32'(4'b0001 << (r % 4)));
        step();
      end
      check_val("t2_idle", 32'(busy),       32'd0);
      check_val("t2_data", 32'(out_data),   32'(8'hC0 + 8'(r % 4)));
      check_val("t2_bc",   32'(beat_count), 32'(4 * (r + 1)));
    end
    req_valid = '0;
    step();
    step();

    // backpressure on requester 1 with 0xA5 held
    req_valid = 4'b0010;
    set_data(1, 8'hA5);
    step();
    check_val("t3_gnt", 32'(grant_idx), 32'd1);
    out_ready = 1'b0;
    #1;
    check_val("t3_ready_empty", 32'(req_ready), 32'b0010);
    step();
    set_data(1, 8'hB6);
    for (int c = 0; c < 3; c++) begin
      check_val("t3_hold_v", 32'(out_valid), 32'd1);
      check_val("t3_hold_d", 32'(out_data),  32'hA5);
      check_val("t3_hold_r", 32'(req_ready), 32'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_val("t3_ready_rel", 32'(req_ready), 32'b0010);
    step();
    check_val("t3_next_v", 32'(out_valid),  32'd1);
    check_val("t3_next_d", 32'(out_data),   32'hB6);
    check_val("t3_bc22",   32'(beat_count), 32'd22);
    set_data(1, 8'hC7);
    req_last[1] = 1'b1;
    step();
    check_val("t3_last_d", 32'(out_data),   32'hC7);
    check_val("t3_last_f", 32'(out_last),   32'd1);
    check_val("t3_rel",    32'(busy),       32'd0);
    check_val("t3_bc23",   32'(beat_count), 32'd23);
    req_valid = '0;
    req_last  = '0;
    step();
    check_val("t3_drain", 32'(out_valid), 32'd0);

    // requester 2 drops valid after 2 beats, requester 3 waiting
    req_valid = 4'b1100;
    set_data(2, 8'h21);
    set_data(3, 8'h31);
    step();
    check_val("t4_gnt2", 32'(grant_idx), 32'd2);
    step();
    set_data(2, 8'h22);
    step();
    req_valid = 4'b1000;
    step();
    check_val("t4_rel",   32'(busy),       32'd0);
    check_val("t4_bc",    32'(beat_count), 32'd25);
    check_val("t4_data",  32'(out_data),   32'h22);
    step();
    check_val("t4_gnt3",  32'(grant_idx),  32'd3);
    check_val("t4_busy3", 32'(busy),       32'd1);
    step();
    check_val("t4_d3",    32'(out_data),   32'h31);
    check_val("t4_bc3",   32'(beat_count), 32'd26);
    req_valid = '0;
    step();
    check_val("t4_rel3",  32'(busy), 32'd0);

    // reset asserted mid-burst during grant 2
    req_valid = 4'b0100;
    set_data(2, 8'h5A);
    step();
    check_val("t5_gnt2", 32'(grant_idx), 32'd2);
    step();
    check_val("t5_pre_v", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_ready", 32'(req_ready),  32'h0);
    check_val("t5_valid", 32'(out_valid),  32'h0);
    check_val("t5_data",  32'(out_data),   32'h0);
    check_val("t5_last",  32'(out_last),   32'h0);
    check_val("t5_gnt",   32'(grant_idx),  32'h0);
    check_val("t5_busy",  32'(busy),       32'h0);
    check_val("t5_bc",    32'(beat_count), 32'h0);
    req_valid = 4'b0101;
    set_data(0, 8'h0A);
    @(negedge clk) reset_n = 1'b1;
    step();
    check_val("t5_gnt0", 32'(grant_idx), 32'd0);
    check_val("t5_busy0", 32'(busy),     32'd1);
    req_valid = '0;
    step();
    step();

    // beat counter wrap on the long-burst instance
    w_req_valid = 2'b01;
    found = 1'b0;
    for (int c = 0; c < 70000 && !found; c++) begin
      step();
      if (w_beat_count == 16'hFFFF) begin
        w_req_valid = '0;
        found = 1'b1;
      end
    end
    check_val("t6_reach", 32'(found), 32'd1);
    step();
    step();
    check_val("t6_ffff", 32'(w_beat_count), 32'hFFFF);
    w_req_valid = 2'b01;
    step();
    check_val("t6_gnt_ffff", 32'(w_beat_count), 32'hFFFF);
    step();
    check_val("t6_0000", 32'(w_beat_count), 32'h0000);
    step();
    check_val("t6_0001", 32'(w_beat_count), 32'h0001);
    w_req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
